// File: rtl/gba_audio_pwm_sampler.sv
// gba_audio_pwm_sampler: GBA PWM audio pins to signed 16-bit stereo PCM on a valid/ready interface.
// Define AUDIO_AVG4_EN to add a per-channel 4-tap moving average (one extra cycle of latency).
module gba_audio_pwm_sampler #(
  parameter int CLK_FREQ0   = 74250000,
  parameter int CLK_FREQ1   = 73660000,
  parameter int SAMPLE_RATE = 48000,
  parameter int CNT_W       = 12,
  parameter int OUT_SHIFT   = 4
) (
  input  logic               pxlClk,
  input  logic               rst,
  input  logic               framerate,
  input  logic               audioLIn,
  input  logic               audioRIn,
  output logic signed [15:0] sampleL,
  output logic signed [15:0] sampleR,
  output logic               sampleValid,
  input  logic               sampleReady,
  output logic               overrun
);
  localparam int FMAX  = CLK_FREQ0 > CLK_FREQ1 ? CLK_FREQ0 : CLK_FREQ1;
  localparam int ACC_W = $clog2(2 * FMAX + 1);
  localparam int C_W   = CNT_W + 2;
  localparam int SW    = C_W + OUT_SHIFT;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic signed [SW-1:0] S_MAX = SW'(32767);
  localparam logic signed [SW-1:0] S_MIN = SW'(-32768);

  function automatic logic signed [15:0] sat(input logic signed [C_W-1:0] c);
    logic signed [SW-1:0] s;
    s = SW'(c) <<< OUT_SHIFT;
    return s > S_MAX ? 16'sh7fff : s < S_MIN ? 16'sh8000 : s[15:0];
  endfunction

  logic [1:0]             sync_l_q, sync_l_d, sync_r_q, sync_r_d;
  logic                   fr_q, fr_d, fr_chg, tick;
  logic [ACC_W-1:0]       acc_q, acc_d, acc_sum, f_sel;
  logic [CNT_W-1:0]       win_q, win_d, hl_q, hl_d, hr_q, hr_d, win_inc, hl_inc, hr_inc;
  logic                   v1_q, v1_d;
  logic signed [C_W-1:0]  cl_q, cl_d, cr_q, cr_d;
  logic signed [15:0]     sample_l_q, sample_l_d, sample_r_q, sample_r_d, new_l, new_r;
  logic                   valid_q, valid_d, ov_q, ov_d, load;
`ifdef AUDIO_AVG4_EN
  logic                   v2_q, v2_d;
  logic signed [15:0]     sl_q, sl_d, sr_q, sr_d;
  logic signed [15:0]     hist_l_q [3], hist_l_d [3], hist_r_q [3], hist_r_d [3];
  logic signed [17:0]     sum_l, sum_r;
`endif

  always_comb begin
    sync_l_d = {sync_l_q[0], audioLIn};
    sync_r_d = {sync_r_q[0], audioRIn};
    fr_d     = framerate;
    fr_chg   = framerate != fr_q;
    f_sel    = framerate ? ACC_W'(CLK_FREQ1) : ACC_W'(CLK_FREQ0);
    acc_sum  = acc_q + ACC_W'(SAMPLE_RATE);
    tick     = !fr_chg && acc_sum >= f_sel;
    acc_d    = fr_chg ? '0 : tick ? acc_sum - f_sel : acc_sum;
    // the tick cycle itself belongs to the closing window
    win_inc  = win_q == CNT_MAX ? win_q : win_q + CNT_W'(1);
    hl_inc   = sync_l_q[1] && hl_q != CNT_MAX ? hl_q + CNT_W'(1) : hl_q;
    hr_inc   = sync_r_q[1] && hr_q != CNT_MAX ? hr_q + CNT_W'(1) : hr_q;
    win_d    = fr_chg || tick ? '0 : win_inc;
    hl_d     = fr_chg || tick ? '0 : hl_inc;
    hr_d     = fr_chg || tick ? '0 : hr_inc;
    v1_d     = tick;
    cl_d     = tick ? $signed({1'b0, hl_inc, 1'b0}) - $signed({2'b00, win_inc}) : cl_q;
    cr_d     = tick ? $signed({1'b0, hr_inc, 1'b0}) - $signed({2'b00, win_inc}) : cr_q;
`ifdef AUDIO_AVG4_EN
    v2_d     = v1_q;
    sl_d     = v1_q ? sat(cl_q) : sl_q;
    sr_d     = v1_q ? sat(cr_q) : sr_q;
    sum_l    = 18'(sl_q) + 18'(hist_l_q[0]) + 18'(hist_l_q[1]) + 18'(hist_l_q[2]);
    sum_r    = 18'(sr_q) + 18'(hist_r_q[0]) + 18'(hist_r_q[1]) + 18'(hist_r_q[2]);
    new_l    = 16'(sum_l >>> 2);
    new_r    = 16'(sum_r >>> 2);
    load     = v2_q;
    hist_l_d = fr_chg ? '{default: '0} : v2_q ? '{sl_q, hist_l_q[0], hist_l_q[1]} : hist_l_q;
    hist_r_d = fr_chg ? '{default: '0} : v2_q ? '{sr_q, hist_r_q[0], hist_r_q[1]} : hist_r_q;
`else
    new_l    = sat(cl_q);
    new_r    = sat(cr_q);
    load     = v1_q;
`endif
    // a load with a simultaneous transfer replaces the consumed pair without overrun
    sample_l_d = load ? new_l : sample_l_q;
    sample_r_d = load ? new_r : sample_r_q;
    valid_d    = load || (valid_q && !sampleReady);
    ov_d       = ov_q || (load && valid_q && !sampleReady);
  end

  always_ff @(posedge pxlClk) begin
    if (rst) begin
      sync_l_q   <= '0;
      sync_r_q   <= '0;
      fr_q       <= 1'b0;
      acc_q      <= '0;
      win_q      <= '0;
      hl_q       <= '0;
      hr_q       <= '0;
      v1_q       <= 1'b0;
      cl_q       <= '0;
      cr_q       <= '0;
      sample_l_q <= '0;
      sample_r_q <= '0;
      valid_q    <= 1'b0;
      ov_q       <= 1'b0;
`ifdef AUDIO_AVG4_EN
      v2_q       <= 1'b0;
      sl_q       <= '0;
      sr_q       <= '0;
      hist_l_q   <= '{default: '0};
      hist_r_q   <= '{default: '0};
`endif
    end else begin
      sync_l_q   <= sync_l_d;
      sync_r_q   <= sync_r_d;
      fr_q       <= fr_d;
      acc_q      <= acc_d;
      win_q      <= win_d;
      hl_q       <= hl_d;
      hr_q       <= hr_d;
      v1_q       <= v1_d;
      cl_q       <= cl_d;
      cr_q       <= cr_d;
      sample_l_q <= sample_l_d;
      sample_r_q <= sample_r_d;
      valid_q    <= valid_d;
      ov_q       <= ov_d;
`ifdef AUDIO_AVG4_EN
      v2_q       <= v2_d;
      sl_q       <= sl_d;
      sr_q       <= sr_d;
      hist_l_q   <= hist_l_d;
      hist_r_q   <= hist_r_d;
`endif
    end
  end

  assign sampleL     = sample_l_q;
  assign sampleR     = sample_r_q;
  assign sampleValid = valid_q;
  assign overrun     = ov_q;
endmodule

// File: tb/tb_gba_audio_pwm_sampler.sv
// tb_gba_audio_pwm_sampler: directed tests on three small-clock instances (basic/framerate, fractional, saturation).
module tb_gba_audio_pwm_sampler;
  logic pxlClk = 0, rst = 1, framerate = 0, audio_l = 0, audio_r = 0, ready = 0;
  logic signed [15:0] a_l, a_r, b_l, b_r, c_l, c_r;
  logic a_v, b_v, c_v, a_ov, b_ov, c_ov;
  int cyc = 0, checks = 0, errors = 0;

  gba_audio_pwm_sampler #(.CLK_FREQ0(1000), .CLK_FREQ1(500), .SAMPLE_RATE(100), .CNT_W(12), .OUT_SHIFT(4)) dut_a (
    .pxlClk(pxlClk), .rst(rst), .framerate(framerate), .audioLIn(audio_l), .audioRIn(audio_r),
    .sampleL(a_l), .sampleR(a_r), .sampleValid(a_v), .sampleReady(ready), .overrun(a_ov));
  gba_audio_pwm_sampler #(.CLK_FREQ0(1000), .CLK_FREQ1(1000), .SAMPLE_RATE(300), .CNT_W(12), .OUT_SHIFT(5)) dut_b (
    .pxlClk(pxlClk), .rst(rst), .framerate(framerate), .audioLIn(audio_l), .audioRIn(audio_r),
    .sampleL(b_l), .sampleR(b_r), .sampleValid(b_v), .sampleReady(ready), .overrun(b_ov));
  gba_audio_pwm_sampler #(.CLK_FREQ0(10000), .CLK_FREQ1(10000), .SAMPLE_RATE(1), .CNT_W(12), .OUT_SHIFT(4)) dut_c (
    .pxlClk(pxlClk), .rst(rst), .framerate(framerate), .audioLIn(audio_l), .audioRIn(audio_r),
    .sampleL(c_l), .sampleR(c_r), .sampleValid(c_v), .sampleReady(ready), .overrun(c_ov));

  always #5 pxlClk = ~pxlClk;
  always @(posedge pxlClk) cyc <= rst ? 0 : cyc + 1;

  task automatic do_reset;
    @(negedge pxlClk);
    rst = 1;
    framerate = 0;
    repeat (3) @(negedge pxlClk);
    rst = 0;
  endtask

  task automatic wait_v(input int sel, input int lim, output int at, output bit ok);
    ok = 0;
    at = -1;
    for (int i = 0; i < lim && !ok; i++) begin
      @(negedge pxlClk);
      if ((sel == 0 && a_v) || (sel == 1 && b_v) || (sel == 2 && c_v)) begin
        ok = 1;
        at = cyc;
      end
    end
  endtask

  task automatic test_reset;
    audio_l = 1;
    audio_r = 1;
    ready = 0;
    rst = 1;
    repeat (4) @(negedge pxlClk);
    checks++; if (a_l !== 0) begin errors++; $display("FAIL reset_l got %0d want 0", a_l); end
    checks++; if (a_r !== 0) begin errors++; $display("FAIL reset_r got %0d want 0", a_r); end
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_v); end
    checks++; if (a_ov !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", a_ov); end
    checks++; if ({b_v, c_v, b_ov, c_ov} !== 4'b0) begin errors++; $display("FAIL reset_bc got %b want 0000", {b_v, c_v, b_ov, c_ov}); end
  endtask

  task automatic test_reset_mid;
    int n;
    audio_l = 1;
    audio_r = 0;
    ready = 0;
    do_reset;
    repeat (9) @(negedge pxlClk);
    rst = 1;
    n = 0;
    repeat (3) begin
      @(negedge pxlClk);
      if (a_v) n++;
    end
    rst = 0;
    repeat (10) begin
      @(negedge pxlClk);
      if (a_v) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL reset_mid_valid got %0d valid cycles want 0", n); end
    checks++; if (a_l !== 0) begin errors++; $display("FAIL reset_mid_l got %0d want 0", a_l); end
  endtask

  task automatic test_main;
    int ec[3] = '{11, 21, 31};
    int el[3] = '{96, 160, 160};
    int at;
    bit ok;
    audio_l = 1;
    audio_r = 0;
    ready = 1;
    do_reset;
    for (int k = 0; k < 3; k++) begin
      wait_v(0, 20, at, ok);
      checks++; if (at !== ec[k]) begin errors++; $display("FAIL main_time[%0d] got %0d want %0d", k, at, ec[k]); end
      checks++; if (a_l !== el[k]) begin errors++; $display("FAIL main_l[%0d] got %0d want %0d", k, a_l, el[k]); end
      checks++; if (a_r !== -160) begin errors++; $display("FAIL main_r[%0d] got %0d want -160", k, a_r); end
    end
  endtask

  task automatic test_duty50;
    int n = 0;
    audio_l = 0;
    audio_r = 1;
    ready = 1;
    do_reset;
    for (int i = 0; i < 40; i++) begin
      @(negedge pxlClk);
      if (a_v) begin
        n++;
        if (n >= 2) begin
          checks++; if (a_l !== 0) begin errors++; $display("FAIL duty50_l[%0d] got %0d want 0", n, a_l); end
          checks++; if (a_r !== 0) begin errors++; $display("FAIL duty50_r[%0d] got %0d want 0", n, a_r); end
        end
      end
      audio_l = ~audio_l;
      audio_r = ~audio_r;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL duty50_count got %0d want 3", n); end
  endtask

  task automatic test_frac;
    int ec[6] = '{5, 8, 11, 15, 18, 21};
    int el[6] = '{0, 96, 96, 128, 96, 96};
    int er[6] = '{-128, -96, -96, -128, -96, -96};
    int at;
    bit ok;
    audio_l = 1;
    audio_r = 0;
    ready = 1;
    do_reset;
    for (int k = 0; k < 6; k++) begin
      wait_v(1, 10, at, ok);
      checks++; if (at !== ec[k]) begin errors++; $display("FAIL frac_time[%0d] got %0d want %0d", k, at, ec[k]); end
      checks++; if (b_l !== el[k]) begin errors++; $display("FAIL frac_l[%0d] got %0d want %0d", k, b_l, el[k]); end
      checks++; if (b_r !== er[k]) begin errors++; $display("FAIL frac_r[%0d] got %0d want %0d", k, b_r, er[k]); end
    end
  endtask

  task automatic test_overrun;
    audio_l = 1;
    audio_r = 0;
    ready = 0;
    do_reset;
    repeat (15) @(negedge pxlClk);
    checks++; if ({a_v, a_ov} !== 2'b10) begin errors++; $display("FAIL ovr_first got v/ov %b want 10", {a_v, a_ov}); end
    checks++; if (a_l !== 96) begin errors++; $display("FAIL ovr_first_l got %0d want 96", a_l); end
    repeat (6) @(negedge pxlClk);
    checks++; if ({a_v, a_ov} !== 2'b11) begin errors++; $display("FAIL ovr_second got v/ov %b want 11", {a_v, a_ov}); end
    checks++; if (a_l !== 160) begin errors++; $display("FAIL ovr_second_l got %0d want 160", a_l); end
    ready = 1;
    @(negedge pxlClk);
    checks++; if ({a_v, a_ov} !== 2'b01) begin errors++; $display("FAIL ovr_drain got v/ov %b want 01", {a_v, a_ov}); end
    ready = 0;
    repeat (9) @(negedge pxlClk);
    checks++; if ({a_v, a_ov} !== 2'b11) begin errors++; $display("FAIL ovr_sticky got v/ov %b want 11", {a_v, a_ov}); end
  endtask

  task automatic test_back_to_back;
    audio_l = 1;
    audio_r = 0;
    ready = 0;
    do_reset;
    repeat (20) @(negedge pxlClk);
    checks++; if (a_v !== 1'b1 || a_l !== 96) begin errors++; $display("FAIL b2b_hold got v=%b l=%0d want v=1 l=96", a_v, a_l); end
    ready = 1;
    @(negedge pxlClk);
    checks++; if ({a_v, a_ov} !== 2'b10) begin errors++; $display("FAIL b2b_swap got v/ov %b want 10", {a_v, a_ov}); end
    checks++; if (a_l !== 160) begin errors++; $display("FAIL b2b_swap_l got %0d want 160", a_l); end
    @(negedge pxlClk);
    checks++; if (a_v !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", a_v); end
  endtask

  task automatic test_framerate;
    int n = 0, at;
    bit ok;
    audio_l = 1;
    audio_r = 0;
    ready = 1;
    do_reset;
    repeat (15) @(negedge pxlClk);
    framerate = 1;
    repeat (6) begin
      @(negedge pxlClk);
      if (a_v) n++;
    end
    checks++; if (n !== 0) begin errors++; $display("FAIL fr_partial got %0d samples want 0", n); end
    @(negedge pxlClk);
    checks++; if (a_v !== 1'b1) begin errors++; $display("FAIL fr_first_valid got %b want 1 at cycle %0d", a_v, cyc); end
    checks++; if (a_l !== 80 || a_r !== -80) begin errors++; $display("FAIL fr_first got %0d/%0d want 80/-80", a_l, a_r); end
    wait_v(0, 10, at, ok);
    checks++; if (at !== 27 || a_l !== 80) begin errors++; $display("FAIL fr_second got cycle %0d l=%0d want cycle 27 l=80", at, a_l); end
    framerate = 0;
  endtask

  task automatic test_sat;
    int at;
    bit ok;
    audio_l = 1;
    audio_r = 0;
    ready = 1;
    do_reset;
    wait_v(2, 10100, at, ok);
    checks++; if (at !== 10001) begin errors++; $display("FAIL sat_time got %0d want 10001", at); end
    checks++; if (c_l !== 32767) begin errors++; $display("FAIL sat_l got %0d want 32767", c_l); end
    checks++; if (c_r !== -32768) begin errors++; $display("FAIL sat_r got %0d want -32768", c_r); end
  endtask

`ifdef AUDIO_AVG4_EN
  task automatic test_avg;
    int el[8] = '{-40, -80, -120, -160, -80, 0, 80, 160};
    int k = 0;
    audio_l = 0;
    audio_r = 0;
    ready = 1;
    do_reset;
    for (int i = 0; i < 82; i++) begin
      @(negedge pxlClk);
      if (cyc == 38) audio_l = 1;
      if (a_v && k < 8) begin
        checks++; if (cyc !== 10 * k + 12) begin errors++; $display("FAIL avg_time[%0d] got %0d want %0d", k, cyc, 10 * k + 12); end
        checks++; if (a_l !== el[k]) begin errors++; $display("FAIL avg_l[%0d] got %0d want %0d", k, a_l, el[k]); end
        k++;
      end
    end
    checks++; if (k !== 8) begin errors++; $display("FAIL avg_count got %0d want 8", k); end
  endtask
`endif

  initial begin
    test_reset;
    test_reset_mid;
`ifdef AUDIO_AVG4_EN
    test_avg;
`else
    test_main;
    test_duty50;
    test_frac;
    test_overrun;
    test_back_to_back;
    test_framerate;
    test_sat;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
